// File: rtl/shift_rx_deser.sv
// Serial-in/parallel-out frame receiver: start bit, N data bits MSB-first, stop bit, valid/ready output buffer.
// Optional even-parity bit and parity_err output when SHIFT_RX_PARITY_EN is defined.
module shift_rx_deser #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_en,
    input  logic         serin,
    input  logic         dout_ready,
    input  logic         clr_overrun,
    output logic [N-1:0] Dout,
    output logic         dout_valid,
    output logic         busy,
    output logic         frame_err,
`ifdef SHIFT_RX_PARITY_EN
    output logic         overrun,
    output logic         parity_err
`else
    output logic         overrun
`endif
);

    localparam int CW = $clog2(N) + 1;

`ifdef SHIFT_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, DATA, STOP, WAIT_IDLE} state_t;
`endif

    state_t        state, state_nxt;
    logic [N-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic          shift_en, cnt_clr, commit, ferr_set;
    logic          load_buf;
`ifdef SHIFT_RX_PARITY_EN
    logic          par_smp, par_bad;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Every transition is gated by bit_en so the FSM holds between bit periods.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        commit    = 1'b0;
        ferr_set  = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
        par_smp   = 1'b0;
`endif
        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!serin) begin
                        state_nxt = DATA;
                        cnt_clr   = 1'b1;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (cnt == CW'(N - 1)) begin
`ifdef SHIFT_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
`ifdef SHIFT_RX_PARITY_EN
                PARITY: begin
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
`endif
                STOP: begin
                    if (serin) begin
                        commit    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    // A line stuck low must not be mistaken for a fresh start bit.
                    if (serin) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign load_buf = commit && (!dout_valid || dout_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            if (cnt_clr)       cnt <= '0;
            else if (shift_en) cnt <= cnt + CW'(1);
            if (shift_en) shreg <= {shreg[N-2:0], serin};
        end
    end

    // Output buffer: a commit into a full, unaccepted buffer drops the new word and flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            if (load_buf) begin
                Dout       <= shreg;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (commit && !load_buf) overrun <= 1'b1;
            else if (clr_overrun)    overrun <= 1'b0;
        end
    end

`ifdef SHIFT_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_smp) par_bad <= (^shreg) ^ serin;
            parity_err <= commit && par_bad;
        end
    end
`endif

endmodule

// File: tb/tb_shift_rx_deser.sv
// Directed bench for shift_rx_deser with N=8; parity scenario compiled only with SHIFT_RX_PARITY_EN.
module tb_shift_rx_deser;
    localparam int N = 8;

    logic         clk, rst_n, bit_en, serin, dout_ready, clr_overrun;
    logic [N-1:0] Dout;
    logic         dout_valid, busy, frame_err, overrun;
`ifdef SHIFT_RX_PARITY_EN
    logic         parity_err;
`endif
    int checks = 0;
    int errors = 0;
    int gap    = 4;

    shift_rx_deser #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .serin(serin),
        .dout_ready(dout_ready), .clr_overrun(clr_overrun),
        .Dout(Dout), .dout_valid(dout_valid), .busy(busy),
        .frame_err(frame_err),
`ifdef SHIFT_RX_PARITY_EN
        .overrun(overrun), .parity_err(parity_err)
`else
        .overrun(overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bit period: bit_en asserted only in the last clock of the slot.
    task automatic send_bit(input logic b);
        serin  = b;
        bit_en = 1'b0;
        repeat (gap - 1) tick();
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
    endtask

    task automatic send_frame(input logic [N-1:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = N - 1; i >= 0; i--) send_bit(d[i]);
`ifdef SHIFT_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
    endtask

    function automatic logic epar(input logic [N-1:0] d);
        return ^d;
    endfunction

    initial begin
        rst_n = 1'b0; bit_en = 1'b0; serin = 1'b1; dout_ready = 1'b1; clr_overrun = 1'b0;
        repeat (3) tick();
        chk("rst_dout", Dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        tick();

        // 1: clean frame A5, consumer always ready
        send_bit(1'b0);
        chk("t1_busy", busy, 1);
        for (int i = N - 1; i >= 0; i--) send_bit(8'hA5 >> i);
`ifdef SHIFT_RX_PARITY_EN
        send_bit(epar(8'hA5));
`endif
        send_bit(1'b1);
        chk("t1_dout", Dout, 8'hA5);
        chk("t1_valid", dout_valid, 1);
        chk("t1_ferr", frame_err, 0);
        chk("t1_busy_done", busy, 0);
        tick();
        chk("t1_valid_drop", dout_valid, 0);
        chk("t1_dout_hold", Dout, 8'hA5);

        // 2: overrun with consumer stalled
        dout_ready = 1'b0;
        send_frame(8'h3C, epar(8'h3C), 1'b1);
        chk("t2_dout1", Dout, 8'h3C);
        chk("t2_ovr0", overrun, 0);
        send_frame(8'hC3, epar(8'hC3), 1'b1);
        chk("t2_dout_kept", Dout, 8'h3C);
        chk("t2_valid", dout_valid, 1);
        chk("t2_ovr1", overrun, 1);
        tick();
        chk("t2_ovr_sticky", overrun, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("t2_ovr_clr", overrun, 0);
        dout_ready = 1'b1;
        tick();
        chk("t2_consumed", dout_valid, 0);

        // 3: framing error, held-low line, then recovery
        send_frame(8'hFF, epar(8'hFF), 1'b0);
        chk("t3_ferr", frame_err, 1);
        chk("t3_valid", dout_valid, 0);
        tick();
        chk("t3_ferr_pulse", frame_err, 0);
        repeat (3) send_bit(1'b0);
        chk("t3_wait_busy", busy, 1);
        chk("t3_no_word", dout_valid, 0);
        send_bit(1'b1);
        chk("t3_idle", busy, 0);
        send_frame(8'h01, epar(8'h01), 1'b1);
        chk("t3_dout", Dout, 8'h01);
        chk("t3_valid2", dout_valid, 1);
        tick();

        // 4: reset in the middle of a frame
        send_bit(1'b0);
        for (int i = N - 1; i >= N - 4; i--) send_bit(8'h55 >> i);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_dout", Dout, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_valid", dout_valid, 0);
        serin = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'hAA, epar(8'hAA), 1'b1);
        chk("t4_dout", Dout, 8'hAA);
        chk("t4_valid", dout_valid, 1);
        tick();

        // 5: bit_en every clock, back-to-back frames
        gap = 1;
        send_frame(8'h12, epar(8'h12), 1'b1);
        chk("t5_dout1", Dout, 8'h12);
        chk("t5_valid1", dout_valid, 1);
        send_frame(8'h34, epar(8'h34), 1'b1);
        chk("t5_dout2", Dout, 8'h34);
        chk("t5_valid2", dout_valid, 1);
        chk("t5_ovr", overrun, 0);
        gap = 4;
        tick();

`ifdef SHIFT_RX_PARITY_EN
        // 6: parity good then bad; the bad word is still delivered
        send_frame(8'h07, 1'b1, 1'b1);
        chk("t6_perr0", parity_err, 0);
        chk("t6_dout0", Dout, 8'h07);
        tick();
        send_frame(8'h07, 1'b0, 1'b1);
        chk("t6_perr1", parity_err, 1);
        chk("t6_dout1", Dout, 8'h07);
        tick();
        chk("t6_perr_pulse", parity_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
